// File: rtl/if_id_buffer_pkg.sv
// Shared IF/ID definitions: assembly states, opcode-class field position and reset constants.
// Decode imports the same class field so both stages agree on what marks a two-word instruction.
package if_id_buffer_pkg;

    typedef enum logic {
        S_W0 = 1'b0,
        S_W1 = 1'b1
    } state_t;

    localparam int IF_ADDR_W  = 32;
    localparam int IF_INSTR_W = 16;
    localparam int CLS_HI     = 15;
    localparam int CLS_LO     = 13;

    localparam logic [IF_ADDR_W-1:0]  IF_RESET_PC     = 32'h0000_0020;
    localparam logic [2:0]            IF_TWO_WORD_CLS = 3'b011;
    localparam logic [IF_INSTR_W-1:0] IF_NOP_WORD     = 16'h0000;

    function automatic logic [2:0] opcode_class(input logic [IF_INSTR_W-1:0] word);
        return word[CLS_HI:CLS_LO];
    endfunction

endpackage

// File: rtl/if_id_buffer_if.sv
// Fetch/hazard/decode signals around the IF/ID buffer.
// The slave modport is the buffer itself; master is whatever surrounds it.
interface if_id_buffer_if #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 16
);
    logic [INSTR_W-1:0] instr_in;
    logic [ADDR_W-1:0]  pc_in;
    logic               in_valid;
    logic               stall;
    logic               flush;
    logic               fetch_en;
    logic [INSTR_W-1:0] instr_out;
    logic [INSTR_W-1:0] imm_out;
    logic [ADDR_W-1:0]  pc_out;
    logic               has_imm;
    logic               out_valid;

    modport master (
        output instr_in, pc_in, in_valid, stall, flush,
        input  fetch_en, instr_out, imm_out, pc_out, has_imm, out_valid
    );

    modport slave (
        input  instr_in, pc_in, in_valid, stall, flush,
        output fetch_en, instr_out, imm_out, pc_out, has_imm, out_valid
    );
endinterface

// File: rtl/if_id_buffer.sv
// IF/ID pipeline register: captures fetched words and assembles opcode+immediate pairs
// into one decode bundle, honouring stall and flush from the hazard unit.
//
// state | meaning
// S_W0  | expecting an opcode word
// S_W1  | opcode of a two-word instruction held, expecting its immediate
module if_id_buffer
    import if_id_buffer_pkg::*;
#(
    parameter int                  ADDR_W       = IF_ADDR_W,
    parameter int                  INSTR_W      = IF_INSTR_W,
    parameter logic [ADDR_W-1:0]   RESET_PC     = IF_RESET_PC,
    parameter logic [2:0]          TWO_WORD_CLS = IF_TWO_WORD_CLS,
    parameter logic [INSTR_W-1:0]  NOP_WORD     = IF_NOP_WORD
) (
    input  logic         clk,
    input  logic         rst,
    if_id_buffer_if.slave bus
);

    state_t state;

    assign bus.fetch_en = ~bus.stall & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_W0;
            bus.instr_out <= NOP_WORD;
            bus.imm_out   <= '0;
            bus.pc_out    <= RESET_PC;
            bus.has_imm   <= 1'b0;
            bus.out_valid <= 1'b0;
        end else if (bus.flush) begin
            // pc_out deliberately held; a half-built two-word instruction is dropped
            state         <= S_W0;
            bus.instr_out <= NOP_WORD;
            bus.imm_out   <= '0;
            bus.has_imm   <= 1'b0;
            bus.out_valid <= 1'b0;
        end else if (!bus.stall) begin
            if (bus.in_valid) begin
                case (state)
                    S_W0: begin
                        bus.instr_out <= bus.instr_in;
                        bus.pc_out    <= bus.pc_in;
                        bus.imm_out   <= '0;
                        bus.has_imm   <= 1'b0;
                        if (opcode_class(bus.instr_in) == TWO_WORD_CLS) begin
                            state         <= S_W1;
                            bus.out_valid <= 1'b0;
                        end else begin
                            state         <= S_W0;
                            bus.out_valid <= 1'b1;
                        end
                    end
                    S_W1: begin
                        // immediate word is never classified; its pc is not the bundle pc
                        state         <= S_W0;
                        bus.imm_out   <= bus.instr_in;
                        bus.has_imm   <= 1'b1;
                        bus.out_valid <= 1'b1;
                    end
                    default: begin
                        state         <= S_W0;
                        bus.out_valid <= 1'b0;
                    end
                endcase
            end else begin
                bus.out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed, table-driven bench for if_id_buffer with hand-computed expected bundles.
module tb_if_id_buffer;

    logic clk = 1'b0;
    logic rst;

    if_id_buffer_if #(.ADDR_W(32), .INSTR_W(16)) bus ();

    if_id_buffer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        fl;
        logic        st;
        logic        iv;
        logic [15:0] instr;
        logic [31:0] pc;
        logic        e_fen;
        logic        e_val;
        logic [15:0] e_instr;
        logic [15:0] e_imm;
        logic [31:0] e_pc;
        logic        e_has;
    } vec_t;

    vec_t vecs[$];
    int   total  = 0;
    int   passed = 0;

    function automatic vec_t mk(logic r, logic fl, logic st, logic iv, logic [15:0] instr,
                                logic [31:0] pc, logic e_fen, logic e_val, logic [15:0] e_instr,
                                logic [15:0] e_imm, logic [31:0] e_pc, logic e_has);
        vec_t v;
        v.r = r; v.fl = fl; v.st = st; v.iv = iv; v.instr = instr; v.pc = pc;
        v.e_fen = e_fen; v.e_val = e_val; v.e_instr = e_instr; v.e_imm = e_imm;
        v.e_pc = e_pc; v.e_has = e_has;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        rst          = v.r;
        bus.flush    = v.fl;
        bus.stall    = v.st;
        bus.in_valid = v.iv;
        bus.instr_in = v.instr;
        bus.pc_in    = v.pc;
    endtask

    task automatic check_fen(input string name, input logic exp);
        total++;
        if (bus.fetch_en === exp) passed++;
        else $display("FAIL %s fetch_en actual=%0b required=%0b", name, bus.fetch_en, exp);
    endtask

    task automatic check_out(input string name, input logic e_val, input logic [15:0] e_instr,
                             input logic [15:0] e_imm, input logic [31:0] e_pc, input logic e_has);
        total++;
        if (bus.out_valid === e_val && bus.instr_out === e_instr && bus.imm_out === e_imm &&
            bus.pc_out === e_pc && bus.has_imm === e_has)
            passed++;
        else
            $display("FAIL %s actual v=%0b i=%h m=%h pc=%h h=%0b required v=%0b i=%h m=%h pc=%h h=%0b",
                     name, bus.out_valid, bus.instr_out, bus.imm_out, bus.pc_out, bus.has_imm,
                     e_val, e_instr, e_imm, e_pc, e_has);
    endtask

    initial begin
        rst = 1'b1; bus.flush = 1'b0; bus.stall = 1'b0; bus.in_valid = 1'b0;
        bus.instr_in = '0; bus.pc_in = '0;

        //              r  fl st iv instr     pc     fen val instr     imm       pc     has
        vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 32'h00, 0, 0, 16'h0000, 16'h0000, 32'h20, 0)); // reset
        vecs.push_back(mk(1, 0, 0, 1, 16'h1111, 32'h99, 0, 0, 16'h0000, 16'h0000, 32'h20, 0)); // reset overrides
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 32'h00, 1, 0, 16'h0000, 16'h0000, 32'h20, 0)); // release, idle
        vecs.push_back(mk(0, 0, 0, 1, 16'h1234, 32'h20, 1, 1, 16'h1234, 16'h0000, 32'h20, 0)); // single word
        vecs.push_back(mk(0, 0, 0, 1, 16'h6ABC, 32'h21, 1, 0, 16'h6ABC, 16'h0000, 32'h21, 0)); // two-word op
        vecs.push_back(mk(0, 0, 0, 1, 16'hFFFF, 32'h22, 1, 1, 16'h6ABC, 16'hFFFF, 32'h21, 1)); // immediate
        vecs.push_back(mk(0, 0, 1, 1, 16'h5555, 32'h30, 0, 1, 16'h6ABC, 16'hFFFF, 32'h21, 1)); // stall x3
        vecs.push_back(mk(0, 0, 1, 1, 16'h5555, 32'h30, 0, 1, 16'h6ABC, 16'hFFFF, 32'h21, 1));
        vecs.push_back(mk(0, 0, 1, 1, 16'h5555, 32'h30, 0, 1, 16'h6ABC, 16'hFFFF, 32'h21, 1));
        vecs.push_back(mk(0, 0, 0, 0, 16'h5555, 32'h30, 1, 0, 16'h6ABC, 16'hFFFF, 32'h21, 1)); // bubble
        vecs.push_back(mk(0, 0, 0, 1, 16'h6001, 32'h40, 1, 0, 16'h6001, 16'h0000, 32'h40, 0)); // word0
        vecs.push_back(mk(0, 1, 0, 1, 16'h7777, 32'h41, 1, 0, 16'h0000, 16'h0000, 32'h40, 0)); // flush
        vecs.push_back(mk(0, 0, 0, 1, 16'h0042, 32'h42, 1, 1, 16'h0042, 16'h0000, 32'h42, 0)); // opcode again
        vecs.push_back(mk(0, 0, 0, 1, 16'h6002, 32'h43, 1, 0, 16'h6002, 16'h0000, 32'h43, 0));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 32'h00, 1, 0, 16'h6002, 16'h0000, 32'h43, 0)); // S_W1 waits
        vecs.push_back(mk(0, 0, 0, 1, 16'h6123, 32'h44, 1, 1, 16'h6002, 16'h6123, 32'h43, 1)); // class-3 imm
        vecs.push_back(mk(0, 0, 0, 1, 16'h6003, 32'h50, 1, 0, 16'h6003, 16'h0000, 32'h50, 0));
        vecs.push_back(mk(0, 1, 1, 1, 16'h1111, 32'h51, 0, 0, 16'h0000, 16'h0000, 32'h50, 0)); // flush beats stall
        vecs.push_back(mk(0, 0, 0, 1, 16'h2222, 32'h52, 1, 1, 16'h2222, 16'h0000, 32'h52, 0)); // back in S_W0
        vecs.push_back(mk(0, 0, 0, 1, 16'h6004, 32'h60, 1, 0, 16'h6004, 16'h0000, 32'h60, 0));
        vecs.push_back(mk(1, 0, 0, 1, 16'h3333, 32'h61, 0, 0, 16'h0000, 16'h0000, 32'h20, 0)); // rst in S_W1
        vecs.push_back(mk(0, 0, 0, 1, 16'h3333, 32'h62, 1, 1, 16'h3333, 16'h0000, 32'h62, 0)); // opcode, not imm
        vecs.push_back(mk(0, 0, 0, 1, 16'h6005, 32'h70, 1, 0, 16'h6005, 16'h0000, 32'h70, 0));
        vecs.push_back(mk(0, 0, 1, 1, 16'hABCD, 32'h71, 0, 0, 16'h6005, 16'h0000, 32'h70, 0)); // stall in S_W1
        vecs.push_back(mk(0, 0, 0, 1, 16'hABCD, 32'h71, 1, 1, 16'h6005, 16'hABCD, 32'h70, 1));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 32'h00, 1, 0, 16'h6005, 16'hABCD, 32'h70, 1)); // one-cycle pulse

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check_fen($sformatf("vec%0d", i), vecs[i].e_fen);
            @(posedge clk);
            #1;
            check_out($sformatf("vec%0d", i), vecs[i].e_val, vecs[i].e_instr, vecs[i].e_imm,
                      vecs[i].e_pc, vecs[i].e_has);
        end

        // back-to-back single words: each edge yields a fresh bundle
        for (int k = 0; k < 4; k++) begin
            logic [15:0] w;
            w = 16'h0100 + 16'(k);
            @(negedge clk);
            rst = 1'b0; bus.flush = 1'b0; bus.stall = 1'b0;
            bus.in_valid = 1'b1; bus.instr_in = w; bus.pc_in = 32'h80 + 32'(k);
            @(posedge clk);
            #1;
            check_out($sformatf("b2b%0d", k), 1'b1, w, 16'h0000, 32'h80 + 32'(k), 1'b0);
        end

        // stall released mid-hold then bubble: out_valid must drop after the hold ends
        @(negedge clk);
        bus.stall = 1'b1; bus.in_valid = 1'b0;
        @(posedge clk); #1;
        check_out("hold_valid", 1'b1, 16'h0103, 16'h0000, 32'h83, 1'b0);
        @(negedge clk);
        bus.stall = 1'b0;
        @(posedge clk); #1;
        check_out("hold_release", 1'b0, 16'h0103, 16'h0000, 32'h83, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
